window_framer: RTL and testbench

WINDOW_FRAMER -- requirements
Module: window_framer

---
 rtl/window_framer_pkg.sv | 19 +
 rtl/window_framer_shiftreg.sv | 22 ++
 rtl/window_framer.sv | 109 ++++++++++
 tb/tb_window_framer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/window_framer_pkg.sv
// Shared types and size helpers for the window framer.
package window_framer_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    VALID = 2'd1,
    HOP   = 2'd2
  } state_t;

  // Total window length: analysis window plus lag tail.
  function automatic int calc_n(input int window_size_bits, input int max_tau);
    return (1 << window_size_bits) + max_tau;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/window_framer_shiftreg.sv
// N-entry sample history; entry 0 oldest, entry DEPTH-1 newest.
module window_framer_shiftreg #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 296
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        shift_en,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic [DEPTH*DATA_WIDTH-1:0] flat
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] hist;

  always_ff @(posedge clk) begin
    if (reset)         hist <= '0;
    else if (shift_en) hist <= {in_data, hist[DEPTH-1:1]};
  end

  assign flat = hist;

endmodule

// File: rtl/window_framer.sv
// Sliding-window framer: publishes an N-sample frame after fill, then every HOP_SIZE accepts.
// Define WINDOW_FRAMER_SNAPSHOT_EN for a snapshot-buffered frame with overrun detection.
module window_framer
  import window_framer_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int WINDOW_SIZE_BITS = 8,
  parameter int MAX_TAU          = 40,
  parameter int HOP_SIZE         = 128,
  localparam int N               = calc_n(WINDOW_SIZE_BITS, MAX_TAU)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [N*DATA_WIDTH-1:0] frame_data,
  output logic                    frame_valid,
  input  logic                    frame_ack,
  output logic                    overrun
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] FILL_LAST = CW'(N - 1);
  localparam logic [CW-1:0] HOP_LAST  = CW'(HOP_SIZE - 1);

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic                    accept, fill_done, hop_done;
  logic [N*DATA_WIDTH-1:0] hist_flat;

  assign frame_valid = (state == VALID);
  assign accept      = in_valid & in_ready;
  assign fill_done   = accept && (cnt == FILL_LAST);
  assign hop_done    = accept && (cnt == HOP_LAST);

  window_framer_shiftreg #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (N)
  ) u_hist (
    .clk     (clk),
    .reset   (reset),
    .shift_en(accept),
    .in_data (in_data),
    .flat    (hist_flat)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (accept) cnt_nxt = cnt + 1'b1;
    case (state)
      FILL: if (fill_done) begin
        state_nxt = VALID;
        cnt_nxt   = '0;
      end
      HOP: if (hop_done) begin
        state_nxt = VALID;
        cnt_nxt   = '0;
      end
      VALID: begin
        // A hop ending here either republishes (with ack) or is dropped; both restart the count.
        if (hop_done) cnt_nxt = '0;
        if (frame_ack && !hop_done) state_nxt = HOP;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef WINDOW_FRAMER_SNAPSHOT_EN
  logic                    publish, drop, ovr_q;
  logic [N*DATA_WIDTH-1:0] snap, hist_nxt;

  // Snapshot must include the sample being accepted this cycle.
  assign hist_nxt = {in_data, hist_flat[N*DATA_WIDTH-1:DATA_WIDTH]};
  assign publish  = ((state == FILL) && fill_done) || ((state == HOP) && hop_done) ||
                    ((state == VALID) && hop_done && frame_ack);
  assign drop     = (state == VALID) && hop_done && !frame_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      snap  <= '0;
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= drop;
      if (publish) snap <= hist_nxt;
    end
  end

  assign in_ready   = ~reset;
  assign frame_data = snap;
  assign overrun    = ovr_q;
`else
  assign in_ready   = ~reset & ~frame_valid;
  assign frame_data = hist_flat;
  assign overrun    = 1'b0;
`endif

endmodule

// File: tb/tb_window_framer.sv
// Directed bench for window_framer; covers both frame-buffer modes via WINDOW_FRAMER_SNAPSHOT_EN.
module tb_window_framer;

  localparam int DW = 8;
  localparam int N  = 296;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [N*DW-1:0] frame_data;
  logic          frame_valid;
  logic          frame_ack;
  logic          overrun;

  int n_chk  = 0;
  int n_fail = 0;
  int sv     = 0;
  int ov_cnt = 0;

  window_framer dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ack  (frame_ack),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (overrun) ov_cnt++;

  typedef struct {
    string      name;
    int         feed;
    bit         ack;
    bit         exp_valid;
    logic [7:0] exp_s0;
    logic [7:0] exp_s295;
  } vec_t;

  vec_t vecs[4];

  function automatic logic [7:0] smp(input int i);
    return frame_data[i*DW +: DW];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    int t = 0;
    in_data  = v;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL push_timeout: in_ready stuck 0 after %0d cycles, expected 1", t);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic push_seq(input int n);
    for (int k = 0; k < n; k++) begin
      push(sv[7:0]);
      sv++;
    end
  endtask

  task automatic ack_pulse();
    frame_ack = 1'b1;
    @(posedge clk);
    #1;
    frame_ack = 1'b0;
  endtask

  // Reset with in_valid and frame_ack asserted; both must be ignored.
  task automatic do_reset(input string tag);
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    frame_ack = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, {31'd0, frame_valid}, 32'd0);
    chk({tag, "_data_zero"}, {31'd0, (frame_data == '0)}, 32'd1);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    in_valid  = 1'b0;
    frame_ack = 1'b0;
    sv        = 0;
  endtask

  initial begin
    logic [N*DW-1:0] ref_frame;
    int  accepts;
    bit  stayed;
    int  bad;

    vecs[0] = '{"fill_295",   295, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[1] = '{"frame1",       1, 1'b0, 1'b1, 8'h00, 8'h27};
    vecs[2] = '{"hop_127",    127, 1'b1, 1'b0, 8'h00, 8'h00};
    vecs[3] = '{"frame2",       1, 1'b0, 1'b1, 8'h80, 8'hA7};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; frame_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset("rst0");

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].ack) begin
        ack_pulse();
        chk({vecs[v].name, "_ack_drop"}, {31'd0, frame_valid}, 32'd0);
      end
      push_seq(vecs[v].feed);
      chk({vecs[v].name, "_valid"}, {31'd0, frame_valid}, {31'd0, vecs[v].exp_valid});
      if (vecs[v].exp_valid) begin
        chk({vecs[v].name, "_s0"}, {24'd0, smp(0)}, {24'd0, vecs[v].exp_s0});
        chk({vecs[v].name, "_s295"}, {24'd0, smp(N-1)}, {24'd0, vecs[v].exp_s295});
      end
    end

    ref_frame = frame_data;
`ifdef WINDOW_FRAMER_SNAPSHOT_EN
    // No ack across a whole hop: the frame is dropped and overrun pulses once.
    ov_cnt = 0;
    stayed = 1'b1;
    for (int k = 0; k < 128; k++) begin
      push(sv[7:0]);
      sv++;
      if (!frame_valid) stayed = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("ovr_pulse_count", ov_cnt, 32'd1);
    chk("ovr_valid_held", {31'd0, stayed}, 32'd1);
    chk("ovr_data_kept", {31'd0, (frame_data == ref_frame)}, 32'd1);
`else
    // Stalled while a frame is held.
    accepts = 0;
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_valid && in_ready) accepts++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("stall_accepts", accepts, 32'd0);
    chk("stall_ready", {31'd0, in_ready}, 32'd0);
    chk("stall_data_const", {31'd0, (frame_data == ref_frame)}, 32'd1);
    chk("stall_valid", {31'd0, frame_valid}, 32'd1);
    chk("no_overrun", ov_cnt, 32'd0);
`endif
    ack_pulse();
    chk("ack2_drop", {31'd0, frame_valid}, 32'd0);

    // Reset mid-hop discards everything; a full refill is needed.
    push_seq(60);
    do_reset("rst_hop");
    push_seq(295);
    chk("refill_295_valid", {31'd0, frame_valid}, 32'd0);
    push_seq(1);
    chk("refill_296_valid", {31'd1 & 32'd0, frame_valid}, 32'd1);
    chk("refill_s0", {24'd0, smp(0)}, 32'h00);
    chk("refill_s295", {24'd0, smp(N-1)}, 32'h27);

    // Same stream with random idle gaps must give an identical frame.
    do_reset("rst_gap");
    for (int k = 0; k < N; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      push(sv[7:0]);
      sv++;
      if (k == N - 2) chk("gap_295_valid", {31'd0, frame_valid}, 32'd0);
    end
    chk("gap_valid", {31'd0, frame_valid}, 32'd1);
    bad = 0;
    for (int i = 0; i < N; i++)
      if (smp(i) !== 8'(i % 256)) bad++;
    chk("gap_frame_mismatches", bad, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
